// File: rtl/pipe_hazard_pkg.sv
// Shared pipeline package for the hazard controller.
// Holds the hazard FSM state encoding, register-index and counter widths,
// and the load-use compare helper.
package pipe_hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // A load writing x0 never creates a dependency.
    function automatic logic load_use_hit(
        input logic             load,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2
    );
        return load && (rd != REG_W'(0)) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hz_perf_cnt.sv
// Hazard performance counters.
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   clr                  synchronous clear of both counters (wins over increment)
//   stall_inc            count one stall cycle
//   redir_inc            count one accepted redirect
//   stall_cnt, redir_cnt free-running counters, wrap modulo 2^CNT_W
module hz_perf_cnt
    import pipe_hazard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             stall_inc,
    input  logic             redir_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] redir_cnt_q;

    // Counter registers; clear has priority over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else if (clr) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (stall_inc) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (redir_inc) redir_cnt_q <= redir_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign redir_cnt = redir_cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch/jump redirect
// flushing and data-memory wait stalls, plus stall/redirect counters.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   LoadE, RdE                         load flag / destination in E
//   Rs1D, Rs2D                         sources of the instruction in D
//   RedirectB                          taken branch/jump resolved in B
//   MemReqM, MemReadyM                 data-memory handshake in M
//   CntClr                             synchronous clear of both counters
//   StallF/D/E/B/M                     hold pipeline registers
//   FlushD/E/B/W                       synchronous clear of pipeline registers
//   StallCnt, RedirCnt                 performance counters
// Stall/flush outputs are combinational from state and inputs (no added
// latency); only the FSM state and counters are registered.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             LoadE,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic             RedirectB,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             CntClr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallB,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushB,
    output logic             FlushW,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] RedirCnt
);

    hz_state_t state;
    hz_state_t state_nxt;
    logic      lu_pending;
    logic      lu_pending_nxt;
    logic      hazard;
    logic      mem_stall;
    logic      redir_acc;

    assign hazard = load_use_hit(LoadE, RdE, Rs1D, Rs2D);

    // Memory keeps priority until it reports ready, whether the wait began
    // this cycle or earlier.
    assign mem_stall = !MemReadyM && (MemReqM || (state == MEM_WAIT));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            lu_pending <= 1'b0;
        end else begin
            state      <= state_nxt;
            lu_pending <= lu_pending_nxt;
        end
    end

    // Next-state and stall/flush decode.
    always_comb begin
        state_nxt      = state;
        lu_pending_nxt = lu_pending;
        redir_acc      = 1'b0;
        StallF         = 1'b0;
        StallD         = 1'b0;
        StallE         = 1'b0;
        StallB         = 1'b0;
        StallM         = 1'b0;
        FlushD         = 1'b0;
        FlushE         = 1'b0;
        FlushB         = 1'b0;
        FlushW         = 1'b0;

        if (mem_stall) begin
            // Freeze F..M, bubble into W; redirect and load-use wait.
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            StallB    = 1'b1;
            StallM    = 1'b1;
            FlushW    = 1'b1;
            state_nxt = MEM_WAIT;
            // Remember the interrupted second bubble cycle.
            if (state == LU_STALL) lu_pending_nxt = 1'b1;
        end else begin
            case (state)
                MEM_WAIT: begin
                    // Ready cycle: pipeline advances, nothing else accepted.
                    state_nxt      = lu_pending ? LU_STALL : RUN;
                    lu_pending_nxt = 1'b0;
                end
                LU_STALL: begin
                    state_nxt = RUN;
                    if (RedirectB) begin
                        redir_acc = 1'b1;
                        FlushD    = 1'b1;
                        FlushE    = 1'b1;
                        FlushB    = 1'b1;
                    end else begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                default: begin
                    if (RedirectB) begin
                        redir_acc = 1'b1;
                        FlushD    = 1'b1;
                        FlushE    = 1'b1;
                        FlushB    = 1'b1;
                        state_nxt = RUN;
                    end else if (hazard) begin
                        StallF    = 1'b1;
                        StallD    = 1'b1;
                        FlushE    = 1'b1;
                        state_nxt = LU_STALL;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            endcase
        end

        // Pipeline controls are quiet while reset is held.
        if (reset) begin
            redir_acc = 1'b0;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallB    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b0;
            FlushE    = 1'b0;
            FlushB    = 1'b0;
            FlushW    = 1'b0;
        end
    end

    hz_perf_cnt u_perf_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (CntClr),
        .stall_inc (StallF),
        .redir_inc (redir_acc),
        .stall_cnt (StallCnt),
        .redir_cnt (RedirCnt)
    );

endmodule
